// File: rtl/axi_lite_core_master.sv
// Bridges the core's single-request data-memory port onto one AXI4-Lite master (one outstanding txn).
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES.
module axi_lite_core_master #(
  parameter int unsigned AXI_AWIDTH     = 32,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    MEM_REQ,
  input  logic                    MEM_WE,
  input  logic [AXI_AWIDTH-1:0]   MEM_ADDR,
  input  logic [AXI_DWIDTH-1:0]   MEM_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] MEM_WSTRB,
  output logic                    MEM_DONE,
  output logic [AXI_DWIDTH-1:0]   MEM_RDATA,
  output logic                    MEM_ERR,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  localparam int unsigned STRB_W = AXI_DWIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  if (TIMEOUT_CYCLES < 2 || (AXI_DWIDTH % 8) != 0) begin : g_bad_cfg
    $error("axi_lite_core_master: unsupported parameter combination");
  end

  logic [2:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  b_seen_q, b_seen_d;
  logic [1:0]            resp_q, resp_d;
  logic                  mem_done_q, mem_done_d;
  logic                  mem_err_q, mem_err_d;
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
  logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_fin, w_fin, b_fin;

  assign aw_hs = awvalid_q & AXI_AWREADY;
  assign w_hs  = wvalid_q  & AXI_WREADY;
  assign b_hs  = bready_q  & AXI_BVALID;
  assign ar_hs = arvalid_q & AXI_ARREADY;
  assign r_hs  = rready_q  & AXI_RVALID;

  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q  | w_hs;
  assign b_fin  = b_seen_q  | b_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state, handshake tracking and response capture
  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_seen_d   = b_seen_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    mem_done_d = 1'b0;
    mem_err_d  = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (MEM_REQ) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_seen_d  = 1'b0;
          resp_d    = 2'b00;
          if (MEM_WE) begin
            awaddr_d  = MEM_ADDR;
            wdata_d   = MEM_WDATA;
            wstrb_d   = MEM_WSTRB;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            araddr_d  = MEM_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WRITE: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (b_hs)  resp_d    = AXI_BRESP;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        b_seen_d  = b_fin;
        if (aw_fin && w_fin) begin
          if (b_fin) begin
            bready_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        if (b_hs) begin
          resp_d   = AXI_BRESP;
          bready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_RD_ADDR, S_RD_DATA: begin
        if (ar_hs) arvalid_d = 1'b0;
        if (r_hs) begin
          rdata_d   = AXI_RDATA;
          resp_d    = AXI_RRESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          state_d   = S_DONE;
        end else if (ar_hs) begin
          state_d   = S_RD_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog: abort with SLVERR once the transaction has used its cycle budget
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q != S_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != S_DONE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        resp_d    = 2'b10;
        state_d   = S_DONE;
      end
    end
`endif

    if (state_d == S_DONE && state_q != S_DONE) begin
      mem_done_d = 1'b1;
      mem_err_d  = (resp_d != 2'b00);
    end
  end

  // State and output registers
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q    <= S_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_seen_q   <= 1'b0;
      resp_q     <= 2'b00;
      mem_done_q <= 1'b0;
      mem_err_q  <= 1'b0;
      rdata_q    <= '0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_seen_q   <= b_seen_d;
      resp_q     <= resp_d;
      mem_done_q <= mem_done_d;
      mem_err_q  <= mem_err_d;
      rdata_q    <= rdata_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign MEM_DONE    = mem_done_q;
  assign MEM_ERR     = mem_err_q;
  assign MEM_RDATA   = rdata_q;
  assign AXI_AWADDR  = awaddr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_core_master.sv
// Directed bench for axi_lite_core_master: cycle-scripted AXI slave, hand-computed expectations.
module tb_axi_lite_core_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_done, mem_err;
  logic [31:0] mem_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_core_master #(
    .AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_WSTRB(mem_wstrb), .MEM_DONE(mem_done), .MEM_RDATA(mem_rdata), .MEM_ERR(mem_err),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Slave readies pulse on their scripted cycle; B/R stay valid from their cycle until accepted.
  // Cycle 0 is the first cycle the master's VALIDs are visible.
  typedef struct {
    int          done_cyc;
    int          done_cnt;
    int          aw_last;
    int          w_last;
    int          b_last;
    int          ar_last;
    logic        err;
    logic [31:0] rd;
  } obs_t;

  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         input int aw_c, input int w_c, input int b_c,
                         input int ar_c, input int r_c, input logic [1:0] resp,
                         input logic [31:0] rd_val, input int rst_at, output obs_t o);
    logic b_done, r_done, b_pend, r_pend;
    b_done = 1'b0; r_done = 1'b0;
    o.done_cyc = -1; o.done_cnt = 0; o.aw_last = -1; o.w_last = -1;
    o.b_last = -1; o.ar_last = -1; o.err = 1'b0; o.rd = '0;
    mem_we = we; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb; mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        if (we) begin
          check_eq({name, "_awaddr"}, awaddr, addr);
          check_eq({name, "_wdata"}, wdata, wd);
          check_eq({name, "_wstrb"}, 32'(wstrb), 32'(strb));
        end else begin
          check_eq({name, "_araddr"}, araddr, addr);
        end
      end
      if (awvalid) o.aw_last = k;
      if (wvalid)  o.w_last  = k;
      if (bready)  o.b_last  = k;
      if (arvalid) o.ar_last = k;
      if (mem_done) begin
        if (o.done_cnt == 0) begin
          o.done_cyc = k; o.err = mem_err; o.rd = mem_rdata;
        end
        o.done_cnt++;
      end
      rst     = (k == rst_at);
      awready = (k == aw_c);
      wready  = (k == w_c);
      bvalid  = (k >= b_c) && !b_done;
      bresp   = resp;
      arready = (k == ar_c);
      rvalid  = (k >= r_c) && !r_done;
      rresp   = resp;
      rdata   = rd_val;
      b_pend  = bvalid && bready;
      r_pend  = rvalid && rready;
      @(posedge clk);
      if (b_pend) b_done = 1'b1;
      if (r_pend) r_done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
  endtask

  obs_t o;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check_eq("rst_done_err", {30'd0, mem_done, mem_err}, 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_addr", awaddr | araddr | wdata, 32'd0);

    // Combined AW/W/B one cycle after VALID
    run_txn("wr1", 1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF, 1, 1, 1, 99, 99, 2'b00, 32'h0, -1, o);
    check_eq("wr1_done_cyc", 32'(o.done_cyc), 32'd2);
    check_eq("wr1_done_cnt", 32'(o.done_cnt), 32'd1);
    check_eq("wr1_aw_last", 32'(o.aw_last), 32'd1);
    check_eq("wr1_w_last", 32'(o.w_last), 32'd1);
    check_eq("wr1_b_last", 32'(o.b_last), 32'd1);
    check_eq("wr1_err", 32'(o.err), 32'd0);

    // Split AW / W / B
    run_txn("wr2", 1'b1, 32'h0000_0040, 32'h0102_0304, 4'h3, 1, 4, 6, 99, 99, 2'b00, 32'h0, -1, o);
    check_eq("wr2_aw_last", 32'(o.aw_last), 32'd1);
    check_eq("wr2_w_last", 32'(o.w_last), 32'd4);
    check_eq("wr2_done_cyc", 32'(o.done_cyc), 32'd7);
    check_eq("wr2_done_cnt", 32'(o.done_cnt), 32'd1);
    check_eq("wr2_err", 32'(o.err), 32'd0);

    // Read with AR wait and later R
    run_txn("rd3", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 99, 99, 99, 2, 5, 2'b00, 32'h1234_5678, -1, o);
    check_eq("rd3_ar_last", 32'(o.ar_last), 32'd2);
    check_eq("rd3_done_cyc", 32'(o.done_cyc), 32'd6);
    check_eq("rd3_rdata", o.rd, 32'h1234_5678);
    check_eq("rd3_err", 32'(o.err), 32'd0);

    // Zero-wait write with SLVERR; read data must stay held
    run_txn("wr4", 1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 0, 0, 0, 99, 99, 2'b10, 32'h0, -1, o);
    check_eq("wr4_done_cyc", 32'(o.done_cyc), 32'd1);
    check_eq("wr4_err", 32'(o.err), 32'd1);
    check_eq("wr4_rdata_held", o.rd, 32'h1234_5678);

    // Zero-wait read, R with AR, DECERR
    run_txn("rd5", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 99, 99, 99, 0, 0, 2'b11, 32'hCAFE_F00D, -1, o);
    check_eq("rd5_done_cyc", 32'(o.done_cyc), 32'd1);
    check_eq("rd5_err", 32'(o.err), 32'd1);
    check_eq("rd5_rdata", o.rd, 32'hCAFE_F00D);

    // B accepted before AW and W complete
    run_txn("wr6", 1'b1, 32'h0000_0010, 32'h0000_00FF, 4'h1, 3, 2, 1, 99, 99, 2'b00, 32'h0, -1, o);
    check_eq("wr6_done_cyc", 32'(o.done_cyc), 32'd4);
    check_eq("wr6_b_last", 32'(o.b_last), 32'd3);
    check_eq("wr6_err", 32'(o.err), 32'd0);

    // Stray responses while idle
    bvalid = 1'b1; rvalid = 1'b1; bresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("stray_ready", {30'd0, bready, rready}, 32'd0);
      check_eq("stray_done", 32'(mem_done), 32'd0);
    end
    bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00;

    // Reset while W/AW pending
    run_txn("rst7", 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 99, 99, 99, 99, 99, 2'b00, 32'h0, 2, o);
    check_eq("rst7_aw_last", 32'(o.aw_last), 32'd2);
    check_eq("rst7_w_last", 32'(o.w_last), 32'd2);
    check_eq("rst7_b_last", 32'(o.b_last), 32'd2);
    check_eq("rst7_done_cnt", 32'(o.done_cnt), 32'd0);

    run_txn("wr8", 1'b1, 32'hF000_0004, 32'h0000_0001, 4'hF, 1, 1, 1, 99, 99, 2'b00, 32'h0, -1, o);
    check_eq("wr8_done_cyc", 32'(o.done_cyc), 32'd2);
    check_eq("wr8_err", 32'(o.err), 32'd0);
    check_eq("wr8_rdata_rst", o.rd, 32'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
    // AWREADY never comes; late B in IDLE is ignored
    run_txn("to9", 1'b1, 32'h0000_0400, 32'h7777_7777, 4'hF, 99, 0, 18, 99, 99, 2'b00, 32'h0, -1, o);
    check_eq("to9_done_cyc", 32'(o.done_cyc), 32'd16);
    check_eq("to9_err", 32'(o.err), 32'd1);
    check_eq("to9_aw_last", 32'(o.aw_last), 32'd15);
    check_eq("to9_w_last", 32'(o.w_last), 32'd0);
    check_eq("to9_done_cnt", 32'(o.done_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
